// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcode constants, requester count and arbiter state type.
package alu_pkg;

    localparam int NUM_REQ = 2;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_EQUAL = 4'b1000;
    localparam logic [3:0] ALU_SLT   = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on a tie the requester that did not win last time is chosen.
module rr_pick2 (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last_grant,
    output logic [1:0] grant,
    output logic       grant_idx
);

    always_comb begin
        grant = 2'b00;
        if (valid0 && valid1) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end else if (valid0) begin
            grant = 2'b01;
        end else if (valid1) begin
            grant = 2'b10;
        end
    end

    assign grant_idx = grant[1];

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters, one operation in flight,
// with operands and result registered on either side of the ALU.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [DATA_WIDTH-1:0]    req0_srca,
    input  logic [DATA_WIDTH-1:0]    req0_srcb,
    input  logic [OPCODE_LENGTH-1:0] req0_op,
    output logic                     rsp0_valid,
    input  logic                     rsp0_ready,
    output logic [DATA_WIDTH-1:0]    rsp0_result,

    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [DATA_WIDTH-1:0]    req1_srca,
    input  logic [DATA_WIDTH-1:0]    req1_srcb,
    input  logic [OPCODE_LENGTH-1:0] req1_op,
    output logic                     rsp1_valid,
    input  logic                     rsp1_ready,
    output logic [DATA_WIDTH-1:0]    rsp1_result,

    output logic [DATA_WIDTH-1:0]    alu_srca,
    output logic [DATA_WIDTH-1:0]    alu_srcb,
    output logic [OPCODE_LENGTH-1:0] alu_op,
    input  logic [DATA_WIDTH-1:0]    alu_result,

    output logic                     busy
);

    arb_state_t                 state_reg, state_next;
    logic                       last_grant_reg, last_grant_next;
    logic                       owner_reg, owner_next;
    logic [DATA_WIDTH-1:0]      srca_reg, srca_next;
    logic [DATA_WIDTH-1:0]      srcb_reg, srcb_next;
    logic [OPCODE_LENGTH-1:0]   op_reg, op_next;
    logic [DATA_WIDTH-1:0]      result_reg, result_next;

    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ-1:0]         rsp_valid;
    logic [NUM_REQ-1:0]         rsp_ready;
    logic [NUM_REQ-1:0]         grant;
    logic                       grant_idx;
    logic                       accept;
    logic                       rsp_done;

    assign req_valid = {req1_valid, req0_valid};
    assign rsp_ready = {rsp1_ready, rsp0_ready};

    rr_pick2 u_pick (
        .valid0     (req_valid[0]),
        .valid1     (req_valid[1]),
        .last_grant (last_grant_reg),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    // Ready is only offered from IDLE, so a busy arbiter leaves requests waiting untouched.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_chan
            assign req_ready[gi] = (state_reg == IDLE) && grant[gi];
            assign rsp_valid[gi] = (state_reg == RESP) && (owner_reg == 1'(gi));
        end
    endgenerate

    assign accept   = |req_ready;
    assign rsp_done = |(rsp_valid & rsp_ready);

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        owner_next      = owner_reg;
        srca_next       = srca_reg;
        srcb_next       = srcb_reg;
        op_next         = op_reg;
        result_next     = result_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    srca_next       = grant_idx ? req1_srca : req0_srca;
                    srcb_next       = grant_idx ? req1_srcb : req0_srcb;
                    op_next         = grant_idx ? req1_op   : req0_op;
                    owner_next      = grant_idx;
                    last_grant_next = grant_idx;
                    state_next      = EXEC;
                end
            end
            EXEC: begin
                result_next = alu_result;
                state_next  = RESP;
            end
            RESP: begin
                if (rsp_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            owner_reg      <= 1'b0;
            srca_reg       <= '0;
            srcb_reg       <= '0;
            op_reg         <= '0;
            result_reg     <= '0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            owner_reg      <= owner_next;
            srca_reg       <= srca_next;
            srcb_reg       <= srcb_next;
            op_reg         <= op_next;
            result_reg     <= result_next;
        end
    end

    assign req0_ready  = req_ready[0];
    assign req1_ready  = req_ready[1];
    assign rsp0_valid  = rsp_valid[0];
    assign rsp1_valid  = rsp_valid[1];
    assign rsp0_result = result_reg;
    assign rsp1_result = result_reg;

    assign alu_srca = srca_reg;
    assign alu_srcb = srcb_reg;
    assign alu_op   = op_reg;
    assign busy     = (state_reg != IDLE);

endmodule
